// File: rtl/udp_rx_formatter_arb.sv
// udp_rx_formatter_arb
// Two-source, packet-granular round-robin arbiter placed directly upstream of
// udp_stream_format. One source is granted per packet: its header is passed
// through, then its data beats until last, then arbitration restarts.
// Header and data paths are combinational muxes; only the grant/state are
// registered.
// Optional feature: define UDP_RX_ARB_STATS_EN to build the per-source
// forwarded-packet counters (otherwise arb_pkt_cnt0/1 are tied to zero).
module udp_rx_formatter_arb #(
  parameter int CNT_W           = 32,
  parameter int IP_ADDR_W       = 32,
  parameter int TOT_LEN_W       = 16,
  parameter int TIMESTAMP_W     = 64,  // width of tracker_stats_struct
  parameter int MAC_INTERFACE_W = 64,
  parameter int MAC_PADBYTES_W  = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  // source 0
  input  logic                       src0_arb_rx_hdr_val,
  input  logic [IP_ADDR_W-1:0]       src0_arb_rx_src_ip,
  input  logic [IP_ADDR_W-1:0]       src0_arb_rx_dst_ip,
  input  logic [TOT_LEN_W-1:0]       src0_arb_rx_udp_len,
  input  logic [TIMESTAMP_W-1:0]     src0_arb_rx_timestamp,
  output logic                       arb_src0_rx_hdr_rdy,
  input  logic                       src0_arb_rx_data_val,
  input  logic [MAC_INTERFACE_W-1:0] src0_arb_rx_data,
  input  logic                       src0_arb_rx_last,
  input  logic [MAC_PADBYTES_W-1:0]  src0_arb_rx_padbytes,
  output logic                       arb_src0_rx_data_rdy,
  // source 1
  input  logic                       src1_arb_rx_hdr_val,
  input  logic [IP_ADDR_W-1:0]       src1_arb_rx_src_ip,
  input  logic [IP_ADDR_W-1:0]       src1_arb_rx_dst_ip,
  input  logic [TOT_LEN_W-1:0]       src1_arb_rx_udp_len,
  input  logic [TIMESTAMP_W-1:0]     src1_arb_rx_timestamp,
  output logic                       arb_src1_rx_hdr_rdy,
  input  logic                       src1_arb_rx_data_val,
  input  logic [MAC_INTERFACE_W-1:0] src1_arb_rx_data,
  input  logic                       src1_arb_rx_last,
  input  logic [MAC_PADBYTES_W-1:0]  src1_arb_rx_padbytes,
  output logic                       arb_src1_rx_data_rdy,
  // destination (formatter)
  output logic                       arb_dst_rx_hdr_val,
  output logic [IP_ADDR_W-1:0]       arb_dst_rx_src_ip,
  output logic [IP_ADDR_W-1:0]       arb_dst_rx_dst_ip,
  output logic [TOT_LEN_W-1:0]       arb_dst_rx_udp_len,
  output logic [TIMESTAMP_W-1:0]     arb_dst_rx_timestamp,
  input  logic                       dst_arb_rx_hdr_rdy,
  output logic                       arb_dst_rx_data_val,
  output logic [MAC_INTERFACE_W-1:0] arb_dst_rx_data,
  output logic                       arb_dst_rx_last,
  output logic [MAC_PADBYTES_W-1:0]  arb_dst_rx_padbytes,
  input  logic                       dst_arb_rx_data_rdy,
  // status
  output logic [CNT_W-1:0]           arb_pkt_cnt0,
  output logic [CNT_W-1:0]           arb_pkt_cnt1,
  output logic                       arb_grant
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  state_e state_q, state_d;
  logic   grant_q, grant_d;
  logic   last_grant_q, last_grant_d;
  logic   hdr_hs;
  logic   pkt_done;

  assign arb_grant = grant_q;
  assign hdr_hs    = arb_dst_rx_hdr_val & dst_arb_rx_hdr_rdy;
  assign pkt_done  = arb_dst_rx_data_val & dst_arb_rx_data_rdy & arb_dst_rx_last;

  // Mux the granted source onto the formatter side; handshakes open only in HDR/DATA
  always_comb begin
    arb_dst_rx_hdr_val   = 1'b0;
    arb_dst_rx_data_val  = 1'b0;
    arb_src0_rx_hdr_rdy  = 1'b0;
    arb_src1_rx_hdr_rdy  = 1'b0;
    arb_src0_rx_data_rdy = 1'b0;
    arb_src1_rx_data_rdy = 1'b0;
    if (grant_q) begin
      arb_dst_rx_src_ip    = src1_arb_rx_src_ip;
      arb_dst_rx_dst_ip    = src1_arb_rx_dst_ip;
      arb_dst_rx_udp_len   = src1_arb_rx_udp_len;
      arb_dst_rx_timestamp = src1_arb_rx_timestamp;
      arb_dst_rx_data      = src1_arb_rx_data;
      arb_dst_rx_last      = src1_arb_rx_last;
      arb_dst_rx_padbytes  = src1_arb_rx_padbytes;
    end else begin
      arb_dst_rx_src_ip    = src0_arb_rx_src_ip;
      arb_dst_rx_dst_ip    = src0_arb_rx_dst_ip;
      arb_dst_rx_udp_len   = src0_arb_rx_udp_len;
      arb_dst_rx_timestamp = src0_arb_rx_timestamp;
      arb_dst_rx_data      = src0_arb_rx_data;
      arb_dst_rx_last      = src0_arb_rx_last;
      arb_dst_rx_padbytes  = src0_arb_rx_padbytes;
    end
    // While reset is asserted nothing may handshake, so a partial packet is dropped cleanly
    if (rst) begin
      arb_dst_rx_hdr_val  = 1'b0;
    end else if (state_q == ST_HDR) begin
      if (grant_q) begin
        arb_dst_rx_hdr_val  = src1_arb_rx_hdr_val;
        arb_src1_rx_hdr_rdy = dst_arb_rx_hdr_rdy;
      end else begin
        arb_dst_rx_hdr_val  = src0_arb_rx_hdr_val;
        arb_src0_rx_hdr_rdy = dst_arb_rx_hdr_rdy;
      end
    end else if (state_q == ST_DATA) begin
      if (grant_q) begin
        arb_dst_rx_data_val  = src1_arb_rx_data_val;
        arb_src1_rx_data_rdy = dst_arb_rx_data_rdy;
      end else begin
        arb_dst_rx_data_val  = src0_arb_rx_data_val;
        arb_src0_rx_data_rdy = dst_arb_rx_data_rdy;
      end
    end else begin
      arb_dst_rx_hdr_val  = 1'b0;
    end
  end

  // Next-state: arbitrate in IDLE only, advance on header accept and on last beat
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ST_IDLE: begin
        if (src0_arb_rx_hdr_val && src1_arb_rx_hdr_val) begin
          grant_d = ~last_grant_q;
          state_d = ST_HDR;
        end else if (src0_arb_rx_hdr_val) begin
          grant_d = 1'b0;
          state_d = ST_HDR;
        end else if (src1_arb_rx_hdr_val) begin
          grant_d = 1'b1;
          state_d = ST_HDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (hdr_hs) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_HDR;
        end
      end
      ST_DATA: begin
        if (pkt_done) begin
          last_grant_d = grant_q;
          state_d      = ST_IDLE;
        end else begin
          state_d = ST_DATA;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, grant and round-robin pointer; last_grant=1 lets source 0 win the first tie
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
    end
  end

`ifdef UDP_RX_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt0_d;
  logic [CNT_W-1:0] cnt1_q, cnt1_d;

  // Count each completed packet against the source that sent it (wraps naturally)
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (pkt_done) begin
      if (grant_q) begin
        cnt1_d = cnt1_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        cnt0_d = cnt0_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
    end else begin
      cnt0_d = cnt0_q;
    end
  end

  // Packet counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= {CNT_W{1'b0}};
      cnt1_q <= {CNT_W{1'b0}};
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign arb_pkt_cnt0 = cnt0_q;
  assign arb_pkt_cnt1 = cnt1_q;
`else
  assign arb_pkt_cnt0 = {CNT_W{1'b0}};
  assign arb_pkt_cnt1 = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_udp_rx_formatter_arb.sv
// Bench for udp_rx_formatter_arb: random packets from two sources, checked
// against a packet-level round-robin model and a per-source beat scoreboard.
module tb_udp_rx_formatter_arb;

  localparam int CNT_W = 32;
  localparam int HMAX  = 512;
  localparam int BMAX  = 4096;
`ifdef UDP_RX_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [15:0] len;
    logic [63:0] ts;
  } hdr_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
    logic [2:0]  pad;
  } beat_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic  s_hval [2];
  logic  s_dval [2];
  logic  hrdy   [2];
  logic  drdy   [2];
  hdr_t  s_hdr  [2];
  beat_t s_beat [2];

  logic             d_hval, d_hrdy, d_dval, d_drdy, d_last, grant;
  logic [31:0]      d_sip, d_dip;
  logic [15:0]      d_len;
  logic [63:0]      d_ts, d_data;
  logic [2:0]       d_pad;
  logic [CNT_W-1:0] cnt0, cnt1;

  udp_rx_formatter_arb #(
    .CNT_W(CNT_W), .IP_ADDR_W(32), .TOT_LEN_W(16), .TIMESTAMP_W(64),
    .MAC_INTERFACE_W(64), .MAC_PADBYTES_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .src0_arb_rx_hdr_val(s_hval[0]), .src0_arb_rx_src_ip(s_hdr[0].sip),
    .src0_arb_rx_dst_ip(s_hdr[0].dip), .src0_arb_rx_udp_len(s_hdr[0].len),
    .src0_arb_rx_timestamp(s_hdr[0].ts), .arb_src0_rx_hdr_rdy(hrdy[0]),
    .src0_arb_rx_data_val(s_dval[0]), .src0_arb_rx_data(s_beat[0].data),
    .src0_arb_rx_last(s_beat[0].last), .src0_arb_rx_padbytes(s_beat[0].pad),
    .arb_src0_rx_data_rdy(drdy[0]),
    .src1_arb_rx_hdr_val(s_hval[1]), .src1_arb_rx_src_ip(s_hdr[1].sip),
    .src1_arb_rx_dst_ip(s_hdr[1].dip), .src1_arb_rx_udp_len(s_hdr[1].len),
    .src1_arb_rx_timestamp(s_hdr[1].ts), .arb_src1_rx_hdr_rdy(hrdy[1]),
    .src1_arb_rx_data_val(s_dval[1]), .src1_arb_rx_data(s_beat[1].data),
    .src1_arb_rx_last(s_beat[1].last), .src1_arb_rx_padbytes(s_beat[1].pad),
    .arb_src1_rx_data_rdy(drdy[1]),
    .arb_dst_rx_hdr_val(d_hval), .arb_dst_rx_src_ip(d_sip), .arb_dst_rx_dst_ip(d_dip),
    .arb_dst_rx_udp_len(d_len), .arb_dst_rx_timestamp(d_ts), .dst_arb_rx_hdr_rdy(d_hrdy),
    .arb_dst_rx_data_val(d_dval), .arb_dst_rx_data(d_data), .arb_dst_rx_last(d_last),
    .arb_dst_rx_padbytes(d_pad), .dst_arb_rx_data_rdy(d_drdy),
    .arb_pkt_cnt0(cnt0), .arb_pkt_cnt1(cnt1), .arb_grant(grant)
  );

  // packet storage per source; driver and scoreboard walk it with separate indices
  hdr_t  hmem [2][HMAX];
  beat_t bmem [2][BMAX];
  int    h_wr [2], b_wr [2], drv_h [2], drv_b [2], sb_h [2], sb_b [2];
  logic  held [2];

  // packet-level model
  int   owner, hdr_src, last_served;
  int   exp_cnt [2];
  logic prev_idle;
  logic prev_p [2];
  int   grant_log [$];
  int   rdy_mode;
  logic gap_en, chk_reset;
  int   n_pass, n_total;

  task automatic check1(input string tag, input logic obs, input logic expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int exp_count(input int s);
    return STATS ? exp_cnt[s] : 0;
  endfunction

  function automatic bit busy();
    return owner >= 0 || hdr_src >= 0 ||
           drv_h[0] < h_wr[0] || drv_h[1] < h_wr[1] ||
           sb_b[0] < b_wr[0] || sb_b[1] < b_wr[1];
  endfunction

  task automatic load_pkt(input int s, input int nbeats);
    hdr_t  h;
    beat_t b;
    h.sip = $urandom;
    h.dip = $urandom;
    h.len = 16'($urandom);
    h.ts  = {$urandom, $urandom};
    hmem[s][h_wr[s]] = h;
    h_wr[s]++;
    for (int i = 0; i < nbeats; i++) begin
      b.data = {$urandom, $urandom};
      b.last = (i == nbeats - 1);
      b.pad  = 3'($urandom);
      bmem[s][b_wr[s]] = b;
      b_wr[s]++;
    end
  endtask

  task automatic drive();
    for (int s = 0; s < 2; s++) begin
      if (drv_h[s] < h_wr[s]) begin
        s_hval[s] = 1'b1;
        s_hdr[s]  = hmem[s][drv_h[s]];
      end else begin
        s_hval[s] = 1'b0;
        s_hdr[s]  = '0;
      end
      if (drv_b[s] < b_wr[s]) begin
        if (held[s] || !gap_en || $urandom_range(3) != 0) begin
          s_dval[s] = 1'b1;
          held[s]   = 1'b1;
        end else begin
          s_dval[s] = 1'b0;
        end
        s_beat[s] = bmem[s][drv_b[s]];
      end else begin
        s_dval[s] = 1'b0;
        s_beat[s] = '0;
      end
    end
    case (rdy_mode)
      1: begin d_hrdy = 1'b1; d_drdy = ~d_drdy; end
      2: begin d_hrdy = 1'($urandom_range(1)); d_drdy = 1'($urandom_range(1)); end
      default: begin d_hrdy = 1'b1; d_drdy = 1'b1; end
    endcase
  endtask

  // compare DUT outputs of the current cycle with the model, then advance the model
  task automatic sample();
    int    o, g;
    hdr_t  h;
    beat_t sb;
    logic  idle_now;
    if (rst) begin
      owner = -1; hdr_src = -1; last_served = 1;
      exp_cnt[0] = 0; exp_cnt[1] = 0;
      prev_idle = 1'b0; prev_p[0] = 1'b0; prev_p[1] = 1'b0;
      return;
    end
    if (chk_reset) begin
      check1("rst_hrdy0", hrdy[0], 1'b0);
      check1("rst_hrdy1", hrdy[1], 1'b0);
      check1("rst_drdy0", drdy[0], 1'b0);
      check1("rst_drdy1", drdy[1], 1'b0);
      check1("rst_dst_hval", d_hval, 1'b0);
      check1("rst_dst_dval", d_dval, 1'b0);
      check1("rst_grant", grant, 1'b0);
      check64("rst_cnt0", 64'(cnt0), 64'd0);
      check64("rst_cnt1", 64'(cnt1), 64'd0);
      chk_reset = 1'b0;
    end
    check64("cnt0", 64'(cnt0), 64'(exp_count(0)));
    check64("cnt1", 64'(cnt1), 64'(exp_count(1)));

    o = owner;
    if (o >= 0) begin
      check1("grant_data", grant, 1'(o));
      check1("dval_pass", d_dval, s_dval[o]);
      check1("drdy_own", drdy[o], d_drdy);
      check1("drdy_other", drdy[1-o], 1'b0);
      if (s_dval[o]) begin
        check64("data_pass", d_data, s_beat[o].data);
        check1("last_pass", d_last, s_beat[o].last);
        check64("pad_pass", 64'(d_pad), 64'(s_beat[o].pad));
      end
      if (d_dval && d_drdy) begin
        sb = bmem[o][sb_b[o]];
        check64("beat_data", d_data, sb.data);
        check1("beat_last", d_last, sb.last);
        sb_b[o]++;
        if (sb.last) begin
          exp_cnt[o]++;
          last_served = o;
          owner = -1;
        end
      end
    end else begin
      check1("drdy0_idle", drdy[0], 1'b0);
      check1("drdy1_idle", drdy[1], 1'b0);
      check1("dval_idle", d_dval, 1'b0);
    end

    if (prev_idle) begin
      check1("hdr_latency", d_hval, prev_p[0] | prev_p[1]);
      if (prev_p[0] || prev_p[1]) begin
        g = (prev_p[0] && prev_p[1]) ? 1 - last_served : (prev_p[0] ? 0 : 1);
        hdr_src = g;
        grant_log.push_back(g);
      end
    end
    idle_now = (o < 0) && (hdr_src < 0);

    if (hdr_src >= 0) begin
      h = hmem[hdr_src][sb_h[hdr_src]];
      check1("hdr_val", d_hval, 1'b1);
      check1("grant_hdr", grant, 1'(hdr_src));
      check64("hdr_sip", 64'(d_sip), 64'(h.sip));
      check64("hdr_dip", 64'(d_dip), 64'(h.dip));
      check64("hdr_len", 64'(d_len), 64'(h.len));
      check64("hdr_ts", d_ts, h.ts);
      check1("hrdy_own", hrdy[hdr_src], d_hrdy);
      check1("hrdy_other", hrdy[1-hdr_src], 1'b0);
      if (d_hval && d_hrdy) begin
        sb_h[hdr_src]++;
        owner   = hdr_src;
        hdr_src = -1;
      end
    end else begin
      check1("hval_off", d_hval, 1'b0);
      check1("hrdy0_off", hrdy[0], 1'b0);
      check1("hrdy1_off", hrdy[1], 1'b0);
    end
    prev_p[0] = s_hval[0];
    prev_p[1] = s_hval[1];
    prev_idle = idle_now;
  endtask

  task automatic tick();
    logic hh [2];
    logic dh [2];
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      hh[s] = s_hval[s] & hrdy[s];
      dh[s] = s_dval[s] & drdy[s];
    end
    sample();
    @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      if (hh[s]) drv_h[s]++;
      if (dh[s]) begin
        drv_b[s]++;
        held[s] = 1'b0;
      end
    end
    drive();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int s = 0; s < 2; s++) begin
      drv_h[s] = h_wr[s]; sb_h[s] = h_wr[s];
      drv_b[s] = b_wr[s]; sb_b[s] = b_wr[s];
      held[s]  = 1'b0;
    end
    drive();
    chk_reset = 1'b1;
    tick();
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (busy() && n < limit) begin
      tick();
      n++;
    end
    check1("drain_timeout", 1'(!busy()), 1'b1);
  endtask

  initial begin
    int base;
    n_pass = 0; n_total = 0;
    owner = -1; hdr_src = -1; last_served = 1;
    exp_cnt[0] = 0; exp_cnt[1] = 0;
    prev_idle = 1'b0; chk_reset = 1'b0;
    rdy_mode = 0; gap_en = 1'b0; d_drdy = 1'b1; d_hrdy = 1'b1;
    for (int s = 0; s < 2; s++) begin
      h_wr[s] = 0; b_wr[s] = 0; drv_h[s] = 0; drv_b[s] = 0;
      sb_h[s] = 0; sb_b[s] = 0; held[s] = 1'b0; prev_p[s] = 1'b0;
    end
    rst = 1'b1;
    drive();
    tick();
    do_reset();

    // source 0 alone, one 3-beat packet
    load_pkt(0, 3);
    drive();
    wait_done(50);
    check64("t1_cnt0", 64'(cnt0), STATS ? 64'd1 : 64'd0);
    check64("t1_cnt1", 64'(cnt1), 64'd0);

    // both sources request continuously: grants alternate 0,1,0,1
    do_reset();
    grant_log.delete();
    load_pkt(0, 2); load_pkt(1, 2); load_pkt(0, 2); load_pkt(1, 2);
    drive();
    wait_done(100);
    check64("alt_count", 64'(grant_log.size()), 64'd4);
    for (int i = 0; i < grant_log.size() && i < 4; i++)
      check1("alt_grant", 1'(grant_log[i]), 1'(i % 2));
    check64("alt_cnt0", 64'(cnt0), STATS ? 64'd2 : 64'd0);
    check64("alt_cnt1", 64'(cnt1), STATS ? 64'd2 : 64'd0);

    // backpressure: dst data rdy toggles during a 4-beat packet from source 1
    base = sb_b[1];
    rdy_mode = 1;
    load_pkt(1, 4);
    drive();
    wait_done(60);
    rdy_mode = 0;
    check64("bp_beats", 64'(sb_b[1] - base), 64'd4);

    // source 1 shows data before its header while source 0 holds DATA
    load_pkt(0, 6);
    drive();
    for (int i = 0; i < 20 && owner != 0; i++) tick();
    check1("stall_owner0", 1'(owner == 0), 1'b1);
    load_pkt(1, 3);
    drive();
    wait_done(80);

    // reset in the middle of a source 0 packet
    base = sb_b[0];
    load_pkt(0, 8);
    drive();
    for (int i = 0; i < 30 && !(owner == 0 && sb_b[0] - base >= 2); i++) tick();
    check1("mid_data_reached", 1'(owner == 0), 1'b1);
    do_reset();
    grant_log.delete();
    load_pkt(0, 1); load_pkt(1, 1);
    drive();
    wait_done(50);
    check64("post_rst_count", 64'(grant_log.size()), 64'd2);
    if (grant_log.size() >= 2) begin
      check1("post_rst_first", 1'(grant_log[0]), 1'b0);
      check1("post_rst_second", 1'(grant_log[1]), 1'b1);
    end

    // random traffic with random backpressure and source gaps
    rdy_mode = 2;
    gap_en = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      int s;
      s = int'($urandom_range(1));
      if ($urandom_range(7) == 0 && h_wr[s] - sb_h[s] < 3 && h_wr[s] < HMAX - 8)
        load_pkt(s, int'($urandom_range(8, 1)));
      tick();
    end
    rdy_mode = 0;
    gap_en = 1'b0;
    wait_done(2000);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/udp_rx_formatter_arb.md
# udp_rx_formatter_arb

Two-source, packet-granular round-robin arbiter that shares one `udp_stream_format` instance (and its checksum engine) between two receive paths, e.g. two IP RX pipes. It sits directly upstream of the formatter. It grants one source per packet, forwards that source's header, then forwards its data beats until `last`, then re-arbitrates. Interfaces on both sides match the formatter's `rx_hdr` / `rx_data` val/rdy interfaces.

## Interface
- `CNT_W`, 32: width of per-source packet counters.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `srcN_arb_rx_hdr_val` in 1: header valid from source N (N = 0, 1; the same applies to every `srcN`/`arb_srcN` port).
- `srcN_arb_rx_src_ip` in `IP_ADDR_W`: header field.
- `srcN_arb_rx_dst_ip` in `IP_ADDR_W`: header field.
- `srcN_arb_rx_udp_len` in `TOT_LEN_W`: header field.
- `srcN_arb_rx_timestamp` in `tracker_stats_struct`: header field.
- `arb_srcN_rx_hdr_rdy` out 1: header ready to source N.
- `srcN_arb_rx_data_val` in 1: data valid from source N.
- `srcN_arb_rx_data` in `MAC_INTERFACE_W`: data beat.
- `srcN_arb_rx_last` in 1: last beat of the packet.
- `srcN_arb_rx_padbytes` in `MAC_PADBYTES_W`: pad byte count.
- `arb_srcN_rx_data_rdy` out 1: data ready to source N.
- `arb_dst_rx_hdr_val`, `_src_ip`, `_dst_ip`, `_udp_len`, `_timestamp` out: header to the formatter (same widths as the source side).
- `dst_arb_rx_hdr_rdy` in 1: header ready from the formatter.
- `arb_dst_rx_data_val`, `_data`, `_last`, `_padbytes` out: data to the formatter.
- `dst_arb_rx_data_rdy` in 1: data ready from the formatter.
- `arb_pkt_cnt0`, `arb_pkt_cnt1` out `CNT_W`: packets forwarded per source.
- `arb_grant` out 1: currently granted source index; meaningful in HDR and DATA.

## Operation
- States:
  - IDLE: no source granted.
  - HDR: forwarding the granted source's header.
  - DATA: forwarding the granted source's data beats.
- IDLE transitions:
  - If any `srcN_arb_rx_hdr_val` is asserted, register the grant and go to HDR.
  - If both are valid, grant the source other than `last_grant`.
  - If only one is valid, grant that source.
- HDR:
  - `arb_dst_rx_hdr_val` equals the granted source's `hdr_val`; the header fields are muxed from the granted source.
  - The granted source's `hdr_rdy` equals `dst_arb_rx_hdr_rdy`.
  - On the val&rdy handshake, go to DATA.
- DATA:
  - The granted source's data val/data/last/padbytes are muxed to dst; its `data_rdy` equals `dst_arb_rx_data_rdy`.
  - On a handshake with `last=1`: set `last_grant` to the granted source, increment that source's counter, and go to IDLE.
- The non-granted source always sees `hdr_rdy=0` and `data_rdy=0`. Outside DATA, both sources see `data_rdy=0`.
- Data beats presented before the source's header is accepted are stalled, never dropped.
- Counters wrap modulo 2^CNT_W.
- Sources obey val/rdy: val and payload stay stable until accepted. The arbiter relies on this for the combinational header and data pass-through.

## Timing
- Reset values:
  - State is IDLE.
  - `last_grant=1`, so source 0 wins the first tie.
  - `arb_grant=0`; counters are 0.
  - All `*_val` and `*_rdy` outputs are 0.
  - Data and header outputs are don't-care while their val is 0.
- Header latency: `srcN hdr_val` rising in IDLE gives `arb_dst_rx_hdr_val` one cycle later.
- Data path adds no register stage: val, rdy and payload are combinational through the mux.
- Between packets: the last-beat handshake (DATA) is followed by one IDLE cycle and then HDR. Minimum gap from last beat to next header valid is 2 cycles.
- A single-beat packet (`last=1` on the first beat) is valid: HDR, then one DATA cycle, then IDLE.
- Sync reset asserted in HDR or DATA aborts immediately: the next cycle is IDLE with all rdy low and counters cleared. The partial packet is not counted.
- Arbitration is only evaluated in IDLE. A request arriving during HDR or DATA waits.

## Configuration
- `UDP_RX_ARB_STATS_EN`:
  - Defined: `arb_pkt_cnt0` and `arb_pkt_cnt1` are registered `CNT_W`-bit counters as described above.
  - Undefined: the counter registers are not compiled; both ports are tied to 0. Arbitration behaviour is identical.

## Test plan
- Source 0 only, one 3-beat packet, dst rdy always 1:
  - dst hdr_val 1 cycle after src0 hdr_val, with fields equal to src0's.
  - 3 data beats pass unchanged; `last` on beat 3.
  - `arb_pkt_cnt0=1`.
- Both sources request continuously with 2-beat packets: grants alternate 0,1,0,1; after 4 packets `cnt0=2`, `cnt1=2`.
- Backpressure: `dst_arb_rx_data_rdy` toggles 1,0,1,0 during a 4-beat packet from source 1. No beat is lost or duplicated, and `arb_src1_rx_data_rdy` mirrors dst rdy.
- Source 1 asserts data_val with its header not yet accepted while source 0 holds DATA: `arb_src1_rx_data_rdy` stays 0 until source 1's HDR handshake completes.
- Reset asserted mid-DATA of a source 0 packet:
  - Next cycle: state IDLE, all rdy 0, counters 0.
  - With both sources then requesting, source 0 is granted first.
- Build without `UDP_RX_ARB_STATS_EN`, rerun the alternation test: identical grant sequence, `arb_pkt_cnt0/1` remain 0.
